// File: rtl/dac_spi_pkg.sv
// Shared definitions for the DAC SPI transmitter: FSM encoding, default
// control field and the two's-complement to offset-binary conversion.
package dac_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } dac_state_t;

  localparam logic [3:0] DAC_CTRL_DEFAULT = 4'b0000;

  // Flipping the sign bit maps -2^(n-1)..2^(n-1)-1 onto 0..2^n-1.
  function automatic logic [31:0] to_offset_binary(input logic [31:0] word,
                                                   input int unsigned sign_bit);
    return word ^ (32'd1 << sign_bit);
  endfunction

endpackage

// File: rtl/dac_spi_tx_12b_sclk_div.sv
// SCLK generator: splits each bit period into a high half and a low half of
// CLK_DIV clocks each; parked high whenever the shifter is not running.
module sclk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic enable,
  output logic sclk,
  output logic bit_end
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             phase_hi;
  logic             half_tick;

  assign half_tick = enable && (div_cnt == DIV_LAST);
  assign bit_end   = half_tick && !phase_hi;
  assign sclk      = phase_hi;

  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // the asynchronous reset branch parks SCLK high the instant resetn drops.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div_cnt  <= '0;
      phase_hi <= 1'b1;
    end else if (!enable) begin
      div_cnt  <= '0;
      phase_hi <= 1'b1;
    end else if (half_tick) begin
      div_cnt  <= '0;
      phase_hi <= !phase_hi;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/dac_spi_tx_12b.sv
// Serialises signed sine samples into SPI frames for a 12-bit DAC:
// {control field, offset-binary sample}, MSB first, sync_n framed, then a gap.
module dac_spi_tx_12b
  import dac_spi_pkg::*;
#(
  parameter int width      = 12,
  parameter int FRAME_BITS = 16,
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4,
  parameter     CTRL_BITS  = DAC_CTRL_DEFAULT
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic signed [width-1:0] sample_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    dac_sclk,
  output logic                    dac_sync_n,
  output logic                    dac_sdata,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int CTRL_W = FRAME_BITS - width;
  localparam int BIT_W  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CTRL_W-1:0] CTRL_FIELD = CTRL_W'(CTRL_BITS);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

  dac_state_t            state, state_nxt;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] frame_word;
  logic [width-1:0]      sample_ob;
  logic [BIT_W-1:0]      bit_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  rst_done;
  logic                  transfer;
  logic                  shift_en;
  logic                  bit_end;
  logic                  sclk_phase;
  logic                  last_bit;
  logic                  gap_last;

  assign sample_ob  = width'(to_offset_binary(32'(sample_in), width - 1));
  assign frame_word = {CTRL_FIELD, sample_ob};
  // rst_done keeps ready low until the first edge after reset release.
  assign transfer   = sample_valid && rst_done && (state == ST_IDLE);
  assign shift_en   = (state == ST_SHIFT);
  assign last_bit   = (bit_cnt == BIT_LAST);
  assign gap_last   = (gap_cnt == GAP_LAST);
  assign busy       = ~sample_ready;

  sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_div (
    .clock   (clock),
    .resetn  (resetn),
    .enable  (shift_en),
    .sclk    (sclk_phase),
    .bit_end (bit_end)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt    = state;
    sample_ready = 1'b0;
    dac_sclk     = 1'b1;
    dac_sync_n   = 1'b1;
    dac_sdata    = 1'b0;
    frame_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        sample_ready = rst_done;
        if (transfer) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        dac_sclk   = sclk_phase;
        dac_sync_n = 1'b0;
        dac_sdata  = shreg[FRAME_BITS-1];
        if (bit_end && last_bit) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        frame_done = (gap_cnt == '0);
        if (gap_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: the shift register and counters are plain flops, so they reset;
  // an aborted frame must never leave stale bits to resume after reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (transfer) begin
        shreg   <= frame_word;
        bit_cnt <= '0;
      end else if (bit_end) begin
        shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
        bit_cnt <= last_bit ? '0 : bit_cnt + BIT_W'(1);
      end
      if (state == ST_GAP && !gap_last) gap_cnt <= gap_cnt + GAP_W'(1);
      else                              gap_cnt <= '0;
    end
  end

endmodule
